pipe_ctrl_v: RTL and testbench
==============================

Name: pipe_ctrl_v

Overview:
- Central pipeline sequencer for the 5-stage core.
- Consumes the hazard unit's load-use stall, the EX branch/jump redirect, a multi-cycle EX unit handshake (mul/div) and the data-memory ready signal.
- Produces per-stage register enables and flushes, plus the PC redirect select.
- Also tracks multi-cycle ops with a watchdog and keeps saturating stall/flush performance counters.

Parameters:
- MC_MAX, 64: max cycles allowed between mc_start and mc_done before a timeout fault.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- hdu_stall  in  1  load-use stall from the hazard detection unit
- ex_redirect  in  1  taken branch/jump resolved in EX
- mc_start  in  1  multi-cycle op in EX begins this cycle (1-cycle pulse)
- mc_done  in  1  multi-cycle op result valid (1-cycle pulse)
- dmem_req  in  1  MEM stage access active
- dmem_ready  in  1  data memory completes access
- pc_en  out  1  PC register enable
- pc_sel  out  1  1 = load redirect target
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_en  out  1  ID/EX register enable
- idex_flush  out  1  ID/EX clear to NOP (bubble)
- exmem_en  out  1  EX/MEM register enable
- exmem_flush  out  1  EX/MEM clear to NOP
- memwb_en  out  1  MEM/WB register enable
- mc_fault  out  1  sticky watchdog timeout
- stall_cnt  out  CNT_W  cycles with pc_en=0 (saturating)
- flush_cnt  out  CNT_W  redirect events (saturating)

Behaviour:
- FSM states and encodings:
  - RUN=2'd0, MC_BUSY=2'd1, MC_DRAIN=2'd2, HALT=2'd3.
- Reset (rst high at a clk edge):
  - state=RUN, watchdog=0, mc_fault=0, counters=0.
  - While rst is high, outputs are forced: all *_en=0, ifid_flush=idex_flush=exmem_flush=1, pc_sel=0.
  - Reset mid-op drops the op; mc_done arriving later while in RUN is ignored.
- Outputs are combinational from registered state plus current inputs. Within RUN and MC_DRAIN, the first matching priority applies:
  - 1. mem_wait (dmem_req & ~dmem_ready): all enables 0, no flushes. Whole pipe frozen, redirect and hdu_stall ignored this cycle.
  - 2. ex_redirect: pc_en=1, pc_sel=1, ifid_flush=1, idex_flush=1, all enables 1.
  - 3. hdu_stall: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1. This produces exactly one bubble per HDU assertion cycle.
  - 4. otherwise: all enables 1, no flush, pc_sel=0.
- RUN transitions:
  - mc_start & ~mem_wait -> MC_BUSY, watchdog cleared.
  - mc_start with mc_done in the same cycle (1-cycle op) -> MC_DRAIN.
- MC_BUSY:
  - pc_en=ifid_en=idex_en=0, exmem_flush=1 (bubble into MEM), exmem_en=1, memwb_en=1. mem_wait still overrides to full freeze.
  - Watchdog increments each cycle.
  - mc_done -> MC_DRAIN.
  - Watchdog reaching MC_MAX-1 without mc_done -> HALT, mc_fault=1.
  - ex_redirect is ignored here; the branch already left EX.
- MC_DRAIN: one cycle, outputs per the RUN priority list (EX/MEM captures the result), then -> RUN. mc_start in MC_DRAIN behaves as in RUN.
- HALT:
  - All enables 0, no flushes, mc_fault=1.
  - Exits only on rst.
- Counters:
  - stall_cnt +1 each non-reset cycle with pc_en=0.
  - flush_cnt +1 each cycle pc_sel=1.
  - Both saturate at all-ones and never wrap.

Decomposition:
- Shared package pipe_ctrl_pkg holds: state encodings (RUN/MC_BUSY/MC_DRAIN/HALT), default MC_MAX, CNT_W.
- One sub-module: sat_counter_v (CNT_W-wide, en, synchronous clear, saturating), instantiated twice.

Test Plan:
- Reset hold: rst=1 for 3 cycles with random inputs -> all *_en=0, all flushes=1, counters 0. After release with no hazards -> all en=1, state RUN.
- Load-use: hdu_stall=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle, next cycle normal; stall_cnt=1.
- Redirect plus stall same cycle: ex_redirect=1, hdu_stall=1 -> pc_sel=1, ifid_flush=idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- Multi-cycle op: mc_start at cycle 10, mc_done at cycle 15 -> cycles 11–15 pc_en=0, exmem_flush=1; cycle 16 MC_DRAIN with exmem_en=1; cycle 17 RUN; stall_cnt=5.
- Memory wait during MC_BUSY: dmem_req=1, dmem_ready=0 for 3 cycles -> all en=0, no flush. Watchdog still counts; fault only at MC_MAX.
- Watchdog: MC_MAX=8, mc_start, no mc_done -> mc_fault=1 after 8 busy cycles, state HALT, stays halted until rst. Both counters saturate at 16'hFFFF under a long stall with forced values.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encodings and
// default sizing of the multi-cycle watchdog and performance counters.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_BUSY  = 2'd1,
    MC_DRAIN = 2'd2,
    HALT     = 2'd3
  } state_e;

  localparam int MC_MAX_DEF = 64;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/sat_counter_v.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead
// of wrapping.
module sat_counter_v #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // Count register: clear wins, then increment unless already saturated
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != '1)) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipe_ctrl_v.sv
// Central 5-stage pipeline sequencer: stage enables/flushes, PC redirect
// select, multi-cycle op watchdog and saturating stall/flush counters.
module pipe_ctrl_v
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_MAX = MC_MAX_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hdu_stall,
  input  logic             ex_redirect,
  input  logic             mc_start,
  input  logic             mc_done,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             mc_fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              WD_W   = (MC_MAX > 2) ? $clog2(MC_MAX) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MC_MAX - 1);

  state_e          state_r, state_s;
  logic [WD_W-1:0] wd_r, wd_s;
  logic            fault_r, fault_s;
  logic            mem_wait_s;
  logic            stall_inc_s;

  assign mem_wait_s = dmem_req & ~dmem_ready;

  // State, watchdog and sticky fault registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
      wd_r    <= '0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_s;
      wd_r    <= wd_s;
      fault_r <= fault_s;
    end
  end

  // Next-state logic; a memory wait blocks a new op from being accepted
  always_comb begin
    state_s = state_r;
    wd_s    = wd_r;
    fault_s = fault_r;
    case (state_r)
      RUN, MC_DRAIN: begin
        if (mc_start && !mem_wait_s) begin
          wd_s    = '0;
          state_s = mc_done ? MC_DRAIN : MC_BUSY;
        end else begin
          state_s = RUN;
        end
      end
      MC_BUSY: begin
        wd_s = wd_r + WD_W'(1);
        if (mc_done) begin
          state_s = MC_DRAIN;
        end else if (wd_r == WD_MAX) begin
          state_s = HALT;
          fault_s = 1'b1;
        end else begin
          state_s = MC_BUSY;
        end
      end
      HALT: begin
        state_s = HALT;
        fault_s = 1'b1;
      end
      default: begin
        state_s = RUN;
      end
    endcase
  end

  // Stage controls; reset forces all stages to clear
  always_comb begin
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      case (state_r)
        RUN, MC_DRAIN: begin
          if (mem_wait_s) begin
            pc_en = 1'b0;
          end else if (ex_redirect) begin
            pc_en      = 1'b1;
            pc_sel     = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (hdu_stall) begin
            // Hold IF/ID and PC, inject one bubble into EX
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
        end
        MC_BUSY: begin
          if (mem_wait_s) begin
            exmem_en = 1'b0;
          end else begin
            exmem_en    = 1'b1;
            exmem_flush = 1'b1;
            memwb_en    = 1'b1;
          end
        end
        HALT: begin
          pc_en = 1'b0;
        end
        default: begin
          pc_en = 1'b0;
        end
      endcase
    end
  end

  assign mc_fault    = fault_r;
  assign stall_inc_s = ~rst & ~pc_en;

  sat_counter_v #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (stall_inc_s),
    .cnt (stall_cnt)
  );

  sat_counter_v #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .en  (pc_sel),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl_v.sv
// Self-checking bench for pipe_ctrl_v: directed scenarios plus randomized
// traffic against a behavioural model; a 4-bit-counter copy exercises saturation.
module tb_pipe_ctrl_v;

  localparam int MC_MAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, hdu_stall = 1'b0, ex_redirect = 1'b0, mc_start = 1'b0;
  logic mc_done = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;

  logic pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, mc_fault;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_pc_en, s_pc_sel, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush;
  logic s_exmem_en, s_exmem_flush, s_memwb_en, s_mc_fault;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  pipe_ctrl_v #(.MC_MAX(MC_MAX), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hdu_stall(hdu_stall), .ex_redirect(ex_redirect),
    .mc_start(mc_start), .mc_done(mc_done), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .pc_sel(pc_sel), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .mc_fault(mc_fault),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl_v #(.MC_MAX(MC_MAX), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .hdu_stall(hdu_stall), .ex_redirect(ex_redirect),
    .mc_start(mc_start), .mc_done(mc_done), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(s_pc_en), .pc_sel(s_pc_sel), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
    .idex_en(s_idex_en), .idex_flush(s_idex_flush), .exmem_en(s_exmem_en),
    .exmem_flush(s_exmem_flush), .memwb_en(s_memwb_en), .mc_fault(s_mc_fault),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  wire [8:0]  obs_o = {pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush,
                       exmem_en, exmem_flush, memwb_en};
  wire [8:0]  obs_so = {s_pc_en, s_pc_sel, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush,
                        s_exmem_en, s_exmem_flush, s_memwb_en};
  wire [59:0] obs_all = {obs_o, stall_cnt, flush_cnt, mc_fault,
                         obs_so, s_stall_cnt, s_flush_cnt, s_mc_fault};

  int n_pass = 0, n_total = 0;

  // Behavioural model: an op is either running (with its age) or the core is halted
  bit   m_halt = 1'b0, m_busy = 1'b0;
  int   m_age = 0, m_stalls = 0, m_flushes = 0;
  logic [8:0]  exp_o;
  logic [59:0] exp_all;

  function automatic int satv(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Expected {pc_en,pc_sel,ifid_en,ifid_flush,idex_en,idex_flush,exmem_en,exmem_flush,memwb_en}
  function automatic logic [8:0] model_out();
    logic mw = dmem_req & ~dmem_ready;
    logic pe = 0, ps = 0, ie = 0, ifl = 0, de = 0, dfl = 0, ee = 0, efl = 0, we = 0;
    if (rst) begin
      ifl = 1; dfl = 1; efl = 1;
    end else if (m_halt || mw) begin
      pe = 0;
    end else if (m_busy) begin
      ee = 1; efl = 1; we = 1;
    end else if (ex_redirect) begin
      pe = 1; ps = 1; ie = 1; ifl = 1; de = 1; dfl = 1; ee = 1; we = 1;
    end else if (hdu_stall) begin
      de = 1; dfl = 1; ee = 1; we = 1;
    end else begin
      pe = 1; ie = 1; de = 1; ee = 1; we = 1;
    end
    return {pe, ps, ie, ifl, de, dfl, ee, efl, we};
  endfunction

  task automatic model_update();
    logic [8:0] o = model_out();
    if (rst) begin
      m_halt = 0; m_busy = 0; m_age = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!o[8]) m_stalls++;
      if (o[7])  m_flushes++;
      if (m_halt) begin
        m_halt = 1;
      end else if (m_busy) begin
        if (mc_done) m_busy = 0;
        else if (m_age + 1 == MC_MAX) begin m_busy = 0; m_halt = 1; end
        else m_age++;
      end else if (mc_start && !(dmem_req && !dmem_ready) && !mc_done) begin
        m_busy = 1; m_age = 0;
      end
    end
  endtask

  task automatic drive(input logic r, h, e, s, d, q, y);
    rst = r; hdu_stall = h; ex_redirect = e; mc_start = s;
    mc_done = d; dmem_req = q; dmem_ready = y;
    #1;
    exp_o   = model_out();
    exp_all = {exp_o, 16'(satv(m_stalls, 65535)), 16'(satv(m_flushes, 65535)), m_halt,
               exp_o, 4'(satv(m_stalls, 15)), 4'(satv(m_flushes, 15)), m_halt};
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      n_total++;
      if (obs_all !== exp_all) $display("FAIL reset_model obs=%h exp=%h", obs_all, exp_all);
      else n_pass++;
      n_total++;
      if ({obs_o, stall_cnt, flush_cnt} !== {9'b000101010, 32'd0})
        $display("FAIL reset_forced obs=%h exp=%h", {obs_o, stall_cnt, flush_cnt}, {9'b000101010, 32'd0});
      else n_pass++;
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (obs_o !== 9'b101010101) $display("FAIL reset_release obs=%b exp=%b", obs_o, 9'b101010101);
    else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (obs_all !== exp_all || obs_o !== 9'b000011101)
      $display("FAIL load_use obs=%h exp=%h", obs_all, exp_all);
    else n_pass++;
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (obs_o !== 9'b101010101 || stall_cnt !== 16'd1)
      $display("FAIL load_use_after obs=%b/%0d exp=%b/1", obs_o, stall_cnt, 9'b101010101);
    else n_pass++;
    tick();
  endtask

  task automatic test_redirect_stall();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (obs_all !== exp_all || obs_o !== 9'b111111101)
      $display("FAIL redirect_stall obs=%h exp=%h", obs_all, exp_all);
    else n_pass++;
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1)
      $display("FAIL redirect_counts obs=%0d/%0d exp=1/1", flush_cnt, stall_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_multicycle();
    int s0 = m_stalls;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (obs_all !== exp_all) $display("FAIL mc_start obs=%h exp=%h", obs_all, exp_all);
    else n_pass++;
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), (i == 4) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      n_total++;
      if (obs_all !== exp_all || obs_o !== 9'b000000111)
        $display("FAIL mc_busy cyc=%0d obs=%h exp=%h", i, obs_all, exp_all);
      else n_pass++;
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (obs_all !== exp_all || obs_o !== 9'b101010101 || stall_cnt !== 16'(s0 + 5))
      $display("FAIL mc_drain obs=%h exp=%h stalls=%0d", obs_all, exp_all, s0 + 5);
    else n_pass++;
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (obs_all !== exp_all || obs_o !== 9'b101010101)
      $display("FAIL mc_run_late_done obs=%h exp=%h", obs_all, exp_all);
    else n_pass++;
    tick();
  endtask

  task automatic test_watchdog();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < MC_MAX; i++) begin
      logic w = (i >= 2 && i < 5);
      drive(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0, w, 1'b0);
      n_total++;
      if (obs_all !== exp_all || obs_o !== (w ? 9'b000000000 : 9'b000000111) || mc_fault !== 1'b0)
        $display("FAIL wd_busy cyc=%0d obs=%h exp=%h", i, obs_all, exp_all);
      else n_pass++;
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      n_total++;
      if (obs_all !== exp_all || obs_o !== 9'd0 || mc_fault !== 1'b1)
        $display("FAIL wd_halt cyc=%0d obs=%h exp=%h", i, obs_all, exp_all);
      else n_pass++;
      tick();
    end
    for (int i = 0; i < 65540; i++) tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (obs_all !== exp_all || stall_cnt !== 16'hFFFF || s_stall_cnt !== 4'hF)
      $display("FAIL stall_saturate obs=%h exp=%h", obs_all, exp_all);
    else n_pass++;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (obs_all !== exp_all || mc_fault !== 1'b0 || stall_cnt !== 16'd0 || obs_o !== 9'b101010101)
      $display("FAIL halt_exit obs=%h exp=%h", obs_all, exp_all);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(5) == 0),
            ($urandom_range(7) == 0), ($urandom_range(3) == 0), 1'($urandom), 1'($urandom));
      n_total++;
      if (obs_all !== exp_all) $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs_all, exp_all);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    test_reset();
    test_load_use();
    test_redirect_stall();
    test_multicycle();
    test_random();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
